// File: rtl/dmem_slave_pkg.sv
// Shared types for the data-memory responder: FSM states, access sizes,
// the latched request bundle and a byte-mask expander.
package dmem_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for little-endian sub-word accesses: store merge,
// load extraction with sign/zero extension, and alignment checking.
module mem_lane_align
    import dmem_slave_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  mask,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [31:0] rep;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] bit_mask;

    always_comb begin
        mask     = 4'b0000;
        rep      = 32'h0;
        misalign = 1'b0;
        unique case (size)
            SIZE_B: begin
                mask = 4'b0001 << addr_lo;
                rep  = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                mask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                rep      = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            SIZE_W: begin
                mask     = 4'b1111;
                rep      = wdata;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                mask = 4'b0000;
            end
        endcase
    end

    // Replicated store data lets the mask alone pick the lanes.
    assign bit_mask = expand_mask(mask);
    assign wword    = (rword & ~bit_mask) | (rep & bit_mask);

    assign byte_v = rword[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata = 32'h0;
        unique case (size)
            SIZE_B:  rdata = {{24{sign_ext & byte_v[7]}}, byte_v};
            SIZE_H:  rdata = {{16{sign_ext & half_v[15]}}, half_v};
            SIZE_W:  rdata = rword;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_slave.sv
// Data-memory responder for the MEM stage: valid/ready request and
// response channels, programmable wait states, byte/half/word accesses.
module dmem_slave
    import dmem_slave_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    req_t        req_q;
    logic        accept;
    logic        do_access;

    logic [31:0] mem [DEPTH_WORDS];
    logic [IW-1:0] idx;
    logic [31:0] rword;

    logic [3:0]  lane_mask;
    logic [31:0] wword;
    logic [31:0] load_data;
    logic        misalign;
    logic        range_err;
    logic        size_err;
    logic        err;

    assign idx   = req_q.addr[IW+1:2];
    assign rword = mem[idx];

    mem_lane_align u_align (
        .addr_lo  (req_q.addr[1:0]),
        .size     (req_q.size),
        .sign_ext (req_q.sign_ext),
        .wdata    (req_q.wdata),
        .rword    (rword),
        .mask     (lane_mask),
        .wword    (wword),
        .rdata    (load_data),
        .misalign (misalign)
    );

    assign range_err = (req_q.addr[31:2] >= DEPTH_L);
    assign size_err  = (req_q.size == SIZE_X);
    assign err       = misalign | size_err | range_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        do_access  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nx  = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            req_q      <= '0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt   <= WAIT_L;
                req_q <= '{
                    we:       req_we,
                    addr:     req_addr,
                    size:     req_size,
                    sign_ext: req_signed,
                    wdata:    req_wdata
                };
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                resp_err   <= err;
                resp_rdata <= (err || req_q.we) ? 32'h0 : load_data;
            end
        end
    end

    // Storage is not reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && do_access && req_q.we && !err && lane_mask != 4'b0000) begin
            mem[idx] <= wword;
        end
    end

endmodule

// File: tb/tb_dmem_slave.sv
// Self-checking bench for dmem_slave: directed scenarios plus randomized
// traffic compared against an arithmetic reference memory.
module tb_dmem_slave;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;
    localparam int LAT   = WAITC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_pass  = 0;
    int n_total = 0;

    bit [31:0] ref_mem [int];

    always #5 clk = ~clk;

    dmem_slave #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    function automatic void ref_access(input bit we, input bit [31:0] addr,
                                       input bit [1:0] size, input bit sgn,
                                       input bit [31:0] wd,
                                       output bit [31:0] rd, output bit er);
        int unsigned widx;
        int unsigned off;
        int unsigned sh;
        bit [31:0]   w;
        widx = addr / 4;
        off  = addr % 4;
        sh   = off * 8;
        rd   = 32'h0;
        er   = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) ||
               (size == 2'd2 && off != 0) || (widx >= DEPTH);
        if (er) return;
        w = ref_mem.exists(int'(widx)) ? ref_mem[int'(widx)] : 32'h0;
        if (we) begin
            case (size)
                2'd0:    w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                2'd1:    w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                default: w = wd;
            endcase
            ref_mem[int'(widx)] = w;
        end else begin
            case (size)
                2'd0: begin
                    rd = (w >> sh) & 32'hFF;
                    if (sgn && rd >= 128) rd = rd | 32'hFFFFFF00;
                end
                2'd1: begin
                    rd = (w >> sh) & 32'hFFFF;
                    if (sgn && rd >= 32768) rd = rd | 32'hFFFF0000;
                end
                default: rd = w;
            endcase
        end
    endfunction

    task automatic do_req(input bit we, input bit [31:0] addr, input bit [1:0] size,
                          input bit sgn, input bit [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wd;
        req_valid  = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready);
        else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid);
        else n_pass++;
        n_total++;
        if (resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", resp_rdata);
        else n_pass++;
        n_total++;
        if (resp_err !== 1'b0) $display("FAIL reset_err got %b want 0", resp_err);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit [31:0]   erd;
        bit          eer;
        do_req(1, 32'h10, 2'd2, 0, 32'hDEADBEEF, rd, er, lat);
        ref_access(1, 32'h10, 2'd2, 0, 32'hDEADBEEF, erd, eer);
        n_total++;
        if (er !== 1'b0 || rd !== 32'h0) $display("FAIL sw_resp got err=%b rd=%h want err=0 rd=0", er, rd);
        else n_pass++;
        do_req(0, 32'h10, 2'd2, 0, 32'h0, rd, er, lat);
        ref_access(0, 32'h10, 2'd2, 0, 32'h0, erd, eer);
        n_total++;
        if (rd !== 32'hDEADBEEF || rd !== erd || er !== 1'b0)
            $display("FAIL lw_data got rd=%h err=%b want rd=deadbeef err=0", rd, er);
        else n_pass++;
        n_total++;
        if (lat !== LAT) $display("FAIL lw_latency got %0d want %0d", lat, LAT);
        else n_pass++;
    endtask

    task automatic test_byte_sign();
        bit          t_we  [6] = '{1, 1, 0, 0, 0, 0};
        bit [31:0]   t_adr [6] = '{32'h10, 32'h13, 32'h10, 32'h13, 32'h13, 32'h12};
        bit [1:0]    t_sz  [6] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1};
        bit          t_sg  [6] = '{0, 0, 0, 1, 0, 1};
        bit [31:0]   t_wd  [6] = '{32'h11223344, 32'h80, 0, 0, 0, 0};
        bit [31:0]   t_exp [6] = '{0, 0, 32'h80223344, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8022};
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit [31:0]   erd;
        bit          eer;
        for (int i = 0; i < 6; i++) begin
            do_req(t_we[i], t_adr[i], t_sz[i], t_sg[i], t_wd[i], rd, er, lat);
            ref_access(t_we[i], t_adr[i], t_sz[i], t_sg[i], t_wd[i], erd, eer);
            n_total++;
            if (rd !== t_exp[i] || rd !== erd || er !== 1'b0)
                $display("FAIL byte_sign[%0d] got rd=%h err=%b want rd=%h err=0", i, rd, er, t_exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        bit          t_we  [5] = '{0, 1, 0, 0, 1};
        bit [31:0]   t_adr [5] = '{32'h11, 32'h12, 32'h10, 32'(4 * DEPTH), 32'(4 * DEPTH + 1)};
        bit [1:0]    t_sz  [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit [31:0]   erd;
        bit          eer;
        for (int i = 0; i < 5; i++) begin
            do_req(t_we[i], t_adr[i], t_sz[i], 1, 32'hCAFEF00D, rd, er, lat);
            ref_access(t_we[i], t_adr[i], t_sz[i], 1, 32'hCAFEF00D, erd, eer);
            n_total++;
            if (er !== 1'b1 || eer !== 1'b1) $display("FAIL err_flag[%0d] got %b want 1", i, er);
            else n_pass++;
            n_total++;
            if (rd !== 32'h0) $display("FAIL err_rdata[%0d] got %h want 0", i, rd);
            else n_pass++;
        end
        do_req(0, 32'h10, 2'd2, 0, 0, rd, er, lat);
        ref_access(0, 32'h10, 2'd2, 0, 0, erd, eer);
        n_total++;
        if (rd !== 32'h80223344 || rd !== erd || er !== 1'b0)
            $display("FAIL err_mem_unchanged got rd=%h err=%b want 80223344", rd, er);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic [31:0] r0;
        logic        er;
        int          lat;
        bit [31:0]   erd;
        bit          eer;
        do_req(1, 32'h18, 2'd2, 0, 32'hA5A5A5A5, rd, er, lat);
        ref_access(1, 32'h18, 2'd2, 0, 32'hA5A5A5A5, erd, eer);
        req_we = 0; req_addr = 32'h10; req_size = 2'd2; req_signed = 0; req_wdata = 0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        r0 = resp_rdata;
        ref_access(0, 32'h10, 2'd2, 0, 0, erd, eer);
        n_total++;
        if (r0 !== erd || lat !== LAT)
            $display("FAIL bp_first got rd=%h lat=%0d want rd=%h lat=%0d", r0, lat, erd, LAT);
        else n_pass++;
        // A store offered during the stalled response must be ignored.
        req_we = 1; req_addr = 32'h18; req_size = 2'd2; req_wdata = 32'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (resp_valid !== 1'b1 || resp_rdata !== r0 || req_ready !== 1'b0)
                $display("FAIL bp_hold[%0d] got valid=%b rd=%h ready=%b want 1 %h 0",
                         i, resp_valid, resp_rdata, req_ready, r0);
            else n_pass++;
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL bp_release got ready=%b valid=%b want 1 0", req_ready, resp_valid);
        else n_pass++;
        do_req(0, 32'h18, 2'd2, 0, 0, rd, er, lat);
        ref_access(0, 32'h18, 2'd2, 0, 0, erd, eer);
        n_total++;
        if (rd !== 32'hA5A5A5A5 || rd !== erd || lat !== LAT)
            $display("FAIL bp_next got rd=%h lat=%0d want a5a5a5a5 lat=%0d", rd, lat, LAT);
        else n_pass++;
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit [31:0]   erd;
        bit          eer;
        bit          seen;
        do_req(1, 32'h20, 2'd2, 0, 32'h12345678, rd, er, lat);
        ref_access(1, 32'h20, 2'd2, 0, 32'h12345678, erd, eer);
        req_we = 1; req_addr = 32'h20; req_size = 2'd2; req_signed = 0; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rst_busy_noresp got seen=%b ready=%b want 0 1", seen, req_ready);
        else n_pass++;
        do_req(0, 32'h20, 2'd2, 0, 0, rd, er, lat);
        ref_access(0, 32'h20, 2'd2, 0, 0, erd, eer);
        n_total++;
        if (rd !== 32'h12345678 || rd !== erd || er !== 1'b0)
            $display("FAIL rst_busy_nowrite got %h want 12345678", rd);
        else n_pass++;
        req_we = 0; req_addr = 32'h20; req_size = 2'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1)
            $display("FAIL rst_resp_drop got valid=%b rd=%h ready=%b want 0 0 1",
                     resp_valid, resp_rdata, req_ready);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit [31:0]   erd;
        bit          eer;
        bit          we;
        bit          sgn;
        bit [1:0]    sz;
        bit [31:0]   adr;
        bit [31:0]   wd;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            do_req(1, 32'(w * 4), 2'd2, 0, wd, rd, er, lat);
            ref_access(1, 32'(w * 4), 2'd2, 0, wd, erd, eer);
        end
        for (int i = 0; i < 80; i++) begin
            we  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            wd  = $urandom;
            if ($urandom_range(0, 7) == 0) adr = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
            else adr = 32'($urandom_range(0, 63));
            do_req(we, adr, sz, sgn, wd, rd, er, lat);
            ref_access(we, adr, sz, sgn, wd, erd, eer);
            n_total++;
            if (rd !== erd || er !== eer || lat !== LAT)
                $display("FAIL rand[%0d] we=%b a=%h sz=%0d s=%b got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                         i, we, adr, sz, sgn, rd, er, lat, erd, eer, LAT);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_sign();
        test_errors();
        test_backpressure();
        test_reset_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
